// File: rtl/router_sync_if.sv
// Signal bundle between the router FSM/FIFOs and router_sync.
// Output handshake: vld_out_n says FIFO n holds data, read_en_n is the reader taking it; a byte leaves on an edge where both are high.
interface router_sync_if;
    logic       detect_addr;
    logic [1:0] din;
    logic       wr_en_req;
    logic       read_en_0, read_en_1, read_en_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] wr_en;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_rst_0, soft_rst_1, soft_rst_2;

    modport slave (
        input  detect_addr, din, wr_en_req,
        input  read_en_0, read_en_1, read_en_2,
        input  empty_0, empty_1, empty_2,
        input  full_0, full_1, full_2,
        output wr_en, fifo_full,
        output vld_out_0, vld_out_1, vld_out_2,
        output soft_rst_0, soft_rst_1, soft_rst_2
    );

    modport master (
        output detect_addr, din, wr_en_req,
        output read_en_0, read_en_1, read_en_2,
        output empty_0, empty_1, empty_2,
        output full_0, full_1, full_2,
        input  wr_en, fifo_full,
        input  vld_out_0, vld_out_1, vld_out_2,
        input  soft_rst_0, soft_rst_1, soft_rst_2
    );
endinterface

// File: rtl/router_sync.sv
// Write steering to the addressed output FIFO plus per-output watchdogs that
// soft-reset a FIFO whose data sits unread for TIMEOUT consecutive cycles.
module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input logic         clk,
    input logic         rst,
    router_sync_if.slave bus
);
    logic [1:0]       addr_q;
    logic [2:0]       vld;
    logic [2:0]       rd;
    logic [2:0]       full;
    logic [2:0]       srst_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [2:0]       wr_en;
    logic             fifo_full;

    assign vld  = ~{bus.empty_2, bus.empty_1, bus.empty_0};
    assign rd   = {bus.read_en_2, bus.read_en_1, bus.read_en_0};
    assign full = {bus.full_2, bus.full_1, bus.full_0};

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 2'd0;
        end else if (bus.detect_addr) begin
            addr_q <= bus.din;
        end
    end

    // Restarting the count on a pulse keeps soft resets at least TIMEOUT apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                cnt_q[n]  <= '0;
                srst_q[n] <= 1'b0;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (!vld[n] || rd[n]) begin
                    cnt_q[n]  <= '0;
                    srst_q[n] <= 1'b0;
                end else if (cnt_q[n] == CNT_W'(TIMEOUT - 1)) begin
                    cnt_q[n]  <= '0;
                    srst_q[n] <= 1'b1;
                end else begin
                    cnt_q[n]  <= cnt_q[n] + 1'b1;
                    srst_q[n] <= 1'b0;
                end
            end
        end
    end

    // Address 3 selects no FIFO; a FIFO is never written while its soft reset is high.
    always_comb begin
        wr_en     = 3'b000;
        fifo_full = 1'b0;
        if (rst) begin
            fifo_full = bus.full_0;
        end else begin
            case (addr_q)
                2'd0: begin
                    wr_en[0]  = bus.wr_en_req & ~srst_q[0];
                    fifo_full = full[0];
                end
                2'd1: begin
                    wr_en[1]  = bus.wr_en_req & ~srst_q[1];
                    fifo_full = full[1];
                end
                2'd2: begin
                    wr_en[2]  = bus.wr_en_req & ~srst_q[2];
                    fifo_full = full[2];
                end
                default: begin
                    wr_en     = 3'b000;
                    fifo_full = 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_en      = wr_en;
    assign bus.fifo_full  = fifo_full;
    assign bus.vld_out_0  = vld[0];
    assign bus.vld_out_1  = vld[1];
    assign bus.vld_out_2  = vld[2];
    assign bus.soft_rst_0 = srst_q[0];
    assign bus.soft_rst_1 = srst_q[1];
    assign bus.soft_rst_2 = srst_q[2];
endmodule

// File: tb/tb_router_sync.sv
// Bench for router_sync: steering vector table, hand-written watchdog
// sequences and a randomized run against a behavioural model.
module tb_router_sync;
    localparam int TIMEOUT = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    router_sync_if bus();

    router_sync #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: a FIFO is soft-reset whenever its run of unread
    // stalled edges reaches a whole multiple of TIMEOUT.
    int         m_addr = 0;
    int         m_run [3] = '{0, 0, 0};
    logic [2:0] m_srst = 3'b000;

    always @(posedge clk) begin
        logic [2:0] stall;
        stall = ~{bus.empty_2, bus.empty_1, bus.empty_0} &
                ~{bus.read_en_2, bus.read_en_1, bus.read_en_0};
        if (rst) begin
            m_addr = 0;
            for (int n = 0; n < 3; n++) m_run[n] = 0;
            m_srst = 3'b000;
        end else begin
            if (bus.detect_addr) m_addr = int'(bus.din);
            for (int n = 0; n < 3; n++) begin
                if (stall[n]) begin
                    m_run[n]  = m_run[n] + 1;
                    m_srst[n] = (m_run[n] % TIMEOUT) == 0;
                end else begin
                    m_run[n]  = 0;
                    m_srst[n] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs to the model, then advance one clock edge.
    task automatic tick();
        logic [2:0] emp, fl, exp_wr;
        logic       exp_full;
        #1;
        emp      = {bus.empty_2, bus.empty_1, bus.empty_0};
        fl       = {bus.full_2, bus.full_1, bus.full_0};
        exp_wr   = 3'b000;
        exp_full = 1'b0;
        if (rst) begin
            exp_full = fl[0];
        end else if (m_addr != 3) begin
            exp_full = fl[m_addr];
            if (bus.wr_en_req && !m_srst[m_addr]) exp_wr[m_addr] = 1'b1;
        end
        check("m_wr_en", {5'd0, bus.wr_en}, {5'd0, exp_wr});
        check("m_fifo_full", {7'd0, bus.fifo_full}, {7'd0, exp_full});
        check("m_vld_out", {5'd0, bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, {5'd0, ~emp});
        check("m_soft_rst", {5'd0, bus.soft_rst_2, bus.soft_rst_1, bus.soft_rst_0}, {5'd0, m_srst});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.detect_addr = 0; bus.din = 0; bus.wr_en_req = 0;
        bus.read_en_0 = 0; bus.read_en_1 = 0; bus.read_en_2 = 0;
        bus.empty_0 = 1; bus.empty_1 = 1; bus.empty_2 = 1;
        bus.full_0 = 0; bus.full_1 = 0; bus.full_2 = 0;
    endtask

    task automatic set_addr(input logic [1:0] a);
        bus.detect_addr = 1; bus.din = a;
        tick();
        bus.detect_addr = 0;
    endtask

    typedef struct {
        logic [1:0] din;
        logic       req;
        logic [2:0] full;
        logic [2:0] exp_wr;
        logic       exp_full;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'd0, 1'b1, 3'b001, 3'b001, 1'b1};
        vecs[1] = '{2'd1, 1'b1, 3'b010, 3'b010, 1'b1};
        vecs[2] = '{2'd2, 1'b1, 3'b100, 3'b100, 1'b1};
        vecs[3] = '{2'd3, 1'b1, 3'b111, 3'b000, 1'b0};
        vecs[4] = '{2'd2, 1'b0, 3'b011, 3'b000, 1'b0};
        vecs[5] = '{2'd1, 1'b1, 3'b101, 3'b010, 1'b0};
        vecs[6] = '{2'd0, 1'b0, 3'b110, 3'b000, 1'b0};
        vecs[7] = '{2'd3, 1'b0, 3'b000, 3'b000, 1'b0};

        set_idle();
        rst = 1;
        @(negedge clk);

        // Reset with arbitrary control inputs
        for (int i = 0; i < 3; i++) begin
            bus.detect_addr = 1'($urandom_range(0, 1));
            bus.din         = 2'($urandom_range(0, 3));
            bus.wr_en_req   = 1'($urandom_range(0, 1));
            bus.read_en_0   = 1'($urandom_range(0, 1));
            bus.full_1      = 1'($urandom_range(0, 1));
            bus.full_2      = 1'($urandom_range(0, 1));
            tick();
            check("rst_wr_en", {5'd0, bus.wr_en}, 8'd0);
            check("rst_fifo_full", {7'd0, bus.fifo_full}, 8'd0);
            check("rst_soft_rst", {5'd0, bus.soft_rst_2, bus.soft_rst_1, bus.soft_rst_0}, 8'd0);
            check("rst_vld_out", {5'd0, bus.vld_out_2, bus.vld_out_1, bus.vld_out_0}, 8'd0);
        end
        set_idle();
        rst = 0;
        bus.wr_en_req = 1;
        #1;
        check("post_rst_addr0", {5'd0, bus.wr_en}, 8'h01);
        tick();

        // Steering table
        for (int i = 0; i < 8; i++) begin
            bus.wr_en_req = 0;
            set_addr(vecs[i].din);
            bus.wr_en_req = vecs[i].req;
            {bus.full_2, bus.full_1, bus.full_0} = vecs[i].full;
            #1;
            check($sformatf("tbl%0d_wr_en", i), {5'd0, bus.wr_en}, {5'd0, vecs[i].exp_wr});
            check($sformatf("tbl%0d_fifo_full", i), {7'd0, bus.fifo_full}, {7'd0, vecs[i].exp_full});
            tick();
        end
        set_idle();

        // New address on the same cycle as a write request
        set_addr(2'd1);
        bus.detect_addr = 1; bus.din = 2'd0; bus.wr_en_req = 1;
        #1;
        check("same_cycle_old", {5'd0, bus.wr_en}, 8'h02);
        tick();
        bus.detect_addr = 0;
        #1;
        check("same_cycle_new", {5'd0, bus.wr_en}, 8'h01);
        tick();
        set_idle();
        tick();

        // Stall on output 1: pulses after 30 and 60 edges
        bus.empty_1 = 0;
        for (int i = 1; i <= 2 * TIMEOUT; i++) begin
            tick();
            check($sformatf("timeout_e%0d", i), {7'd0, bus.soft_rst_1}, {7'd0, (i % TIMEOUT) == 0});
            check($sformatf("timeout_other_e%0d", i), {6'd0, bus.soft_rst_2, bus.soft_rst_0}, 8'd0);
        end
        set_idle();
        tick();

        // Read on edge 29 restarts the count
        bus.empty_1 = 0;
        for (int i = 1; i <= 59; i++) begin
            bus.read_en_1 = (i == 29);
            tick();
            check($sformatf("rescue_e%0d", i), {7'd0, bus.soft_rst_1}, {7'd0, i == 59});
        end
        set_idle();
        tick();

        // Reset on edge 20 discards the count
        bus.empty_1 = 0;
        for (int i = 1; i <= 50; i++) begin
            rst = (i == 20);
            tick();
            check($sformatf("rst_mid_e%0d", i), {7'd0, bus.soft_rst_1}, {7'd0, i == 50});
        end
        rst = 0;
        set_idle();
        tick();

        // Write blocked during soft reset of the addressed FIFO
        set_addr(2'd0);
        bus.wr_en_req = 1; bus.empty_0 = 0;
        for (int i = 1; i <= TIMEOUT + 2; i++) begin
            tick();
            check($sformatf("wr_block_e%0d", i), {5'd0, bus.wr_en}, (i == TIMEOUT) ? 8'h00 : 8'h01);
        end
        set_idle();
        tick();

        // Simultaneous stall on outputs 0 and 2
        bus.empty_0 = 0; bus.empty_2 = 0;
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            tick();
            check($sformatf("dual_e%0d", i), {5'd0, bus.soft_rst_2, bus.soft_rst_1, bus.soft_rst_0},
                  (i == TIMEOUT) ? 8'h05 : 8'h00);
        end
        set_idle();
        tick();

        // Randomized traffic biased toward stalls
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            bus.detect_addr = ($urandom_range(0, 19) == 0);
            bus.din         = 2'($urandom_range(0, 3));
            bus.wr_en_req   = 1'($urandom_range(0, 1));
            bus.empty_0     = ($urandom_range(0, 9) == 0);
            bus.empty_1     = ($urandom_range(0, 29) == 0);
            bus.empty_2     = ($urandom_range(0, 4) == 0);
            bus.read_en_0   = ($urandom_range(0, 49) == 0);
            bus.read_en_1   = ($urandom_range(0, 99) == 0);
            bus.read_en_2   = ($urandom_range(0, 29) == 0);
            bus.full_0      = 1'($urandom_range(0, 1));
            bus.full_1      = 1'($urandom_range(0, 1));
            bus.full_2      = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_sync.md
# router_sync

Synchronizer and write-steering controller between the router FSM controller and the three output FIFOs of the 1x3 router. Latches the destination address from the header byte, steers the controller's write request to the addressed FIFO, and reports that FIFO's full flag back. Per-output watchdog counters generate a one-cycle soft reset to any FIFO whose valid data goes unread for TIMEOUT consecutive cycles.

## Interface

Parameters:
- TIMEOUT, 30, consecutive unread cycles before soft reset; legal range 2..2^CNT_W.
- CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- detect_addr  in  1  FSM in decode-address state; qualifies din as header address.
- din  in  2  address field of header byte.
- wr_en_req  in  1  FSM write request for current packet byte.
- read_en_0 / read_en_1 / read_en_2  in  1 each  destination read strobes.
- empty_0 / empty_1 / empty_2  in  1 each  FIFO empty flags.
- full_0 / full_1 / full_2  in  1 each  FIFO full flags.
- wr_en  out  3  one-hot FIFO write enables; bit n drives FIFO n.
- fifo_full  out  1  full flag of the addressed FIFO.
- vld_out_0 / vld_out_1 / vld_out_2  out  1 each  data available at output n.
- soft_rst_0 / soft_rst_1 / soft_rst_2  out  1 each  registered one-cycle soft reset to FIFO n (also to FSM).

## Operation

- Address register addr_q (2 bits): on an edge with detect_addr=1, addr_q <= din; otherwise holds. Reset value 0.
- addr_q=3 is the invalid destination: wr_en=3'b000 and fifo_full=0 while addr_q=3.
- wr_en (combinational): wr_en[addr_q] = wr_en_req & ~soft_rst_[addr_q]; other bits 0.
  - A FIFO is never written in the cycle its soft reset is high.
- fifo_full (combinational): full_[addr_q] for addr_q in 0..2; 0 for addr_q=3.
- vld_out_n (combinational) = ~empty_n.
- Watchdog n (one instance per output, counter cnt_n, CNT_W bits):
  - If vld_out_n=0 or read_en_n=1: cnt_n <= 0; soft_rst_n <= 0.
  - Else, if cnt_n == TIMEOUT-1: cnt_n <= 0; soft_rst_n <= 1.
  - Else: cnt_n <= cnt_n+1; soft_rst_n <= 0.
- Because cnt_n restarts at 0, soft_rst_n is never high on two consecutive cycles. A stalled output pulses once every TIMEOUT cycles until read or emptied.
- The three watchdogs are fully independent. Simultaneous timeouts on several outputs pulse each of those outputs in the same cycle.
- Reset priority: rst=1 overrides all inputs. addr_q, cnt_0..2 and soft_rst_0..2 all go to 0.
  - Reset-state outputs: wr_en=0, fifo_full=full_0, vld_out_n=~empty_n.
  - Reset asserted mid-count discards the count; no pulse is emitted.

## Timing

- Address latency: 1 cycle. din sampled on the detect_addr edge steers wr_en and fifo_full from the next cycle.
- detect_addr and wr_en_req high in the same cycle: wr_en uses the old addr_q. The new address applies only after the edge.
- wr_en, fifo_full and vld_out_n are combinational from current inputs and addr_q, with zero latency.
- Soft reset latency:
  - With vld_out_n=1 and read_en_n=0 held from edge k, soft_rst_n is high for exactly the cycle following edge k+TIMEOUT-1, i.e. after TIMEOUT sampling edges.
  - read_en_n=1 on any of those edges, including the final one, clears the count with no pulse.
- vld_out_n dropping on the final edge also suppresses the pulse.

## Test plan

- Reset: drive rst=1 with arbitrary inputs for 3 cycles, empty_n=1, full_0=0 -> wr_en=000, fifo_full=0, soft_rst_n=0, vld_out_n=0; addr_q=0 observed via wr_en_req=1 giving wr_en=001.
- Steering: detect_addr=1, din=2 for one edge, then wr_en_req=1 with full_2=1 -> wr_en=100 and fifo_full=1 from the next cycle. Repeat with din=3 -> wr_en=000, fifo_full=0.
- Same-cycle: addr_q=1, then detect_addr=1, din=0, wr_en_req=1 in one cycle -> wr_en=010 that cycle, 001 the cycle after.
- Timeout: TIMEOUT=30, empty_1=0, read_en_1=0 held -> soft_rst_1 high for exactly one cycle after 30 edges, again 30 cycles later. soft_rst_0 and soft_rst_2 stay 0.
- Read rescue: same stall, read_en_1=1 on edge 29 -> no pulse, and count restarts (next pulse only after 30 more unread edges). Also assert rst at edge 20 -> no pulse.
- Write blocking: addr_q=0, wr_en_req=1, output 0 timing out -> wr_en=000 in the soft_rst_0 cycle, 001 in the cycles around it. Simultaneous stall on outputs 0 and 2 from the same edge -> soft_rst_0 and soft_rst_2 pulse together.
